// File: rtl/apb_master_param.sv
// apb_master_param: APB4 requester running one SETUP->ACCESS transfer per accepted command,
// with PSTRB/PPROT, back-to-back issue and an optional stall timeout.
module apb_master_param #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16,
    localparam int STRB_W        = DATA_W / 8
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [STRB_W-1:0] cmd_strb,
    input  logic [2:0]        cmd_prot,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic [STRB_W-1:0] pstrb,
    output logic [2:0]        pprot,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);
    localparam int CNT_W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              psel_nx, penable_nx, pwrite_nx;
    logic [ADDR_W-1:0] paddr_nx;
    logic [DATA_W-1:0] pwdata_nx, rsp_rdata_nx;
    logic [STRB_W-1:0] pstrb_nx;
    logic [2:0]        pprot_nx;
    logic              rsp_valid_nx, rsp_err_nx, rsp_timeout_nx;
    logic              expire;

    assign cmd_ready = (state == IDLE) | ((state == ACCESS) & pready);
    // The abort fires on the edge where the stalled count would reach TIMEOUT_CYCLES.
    assign expire = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

    always_comb begin
        state_nx       = state;
        cnt_nx         = cnt;
        psel_nx        = psel;
        penable_nx     = penable;
        pwrite_nx      = pwrite;
        paddr_nx       = paddr;
        pwdata_nx      = pwdata;
        pstrb_nx       = pstrb;
        pprot_nx       = pprot;
        rsp_valid_nx   = 1'b0;
        rsp_rdata_nx   = '0;
        rsp_err_nx     = 1'b0;
        rsp_timeout_nx = 1'b0;
        case (state)
            IDLE: if (cmd_valid) begin
                psel_nx  = 1'b1;
                state_nx = SETUP;
            end
            SETUP: begin
                penable_nx = 1'b1;
                cnt_nx     = '0;
                state_nx   = ACCESS;
            end
            ACCESS: if (pready) begin
                rsp_valid_nx = 1'b1;
                rsp_rdata_nx = pwrite ? '0 : prdata;
                rsp_err_nx   = pslverr;
                psel_nx      = cmd_valid;
                penable_nx   = 1'b0;
                state_nx     = cmd_valid ? SETUP : IDLE;
            end else if (expire) begin
                psel_nx        = 1'b0;
                penable_nx     = 1'b0;
                rsp_valid_nx   = 1'b1;
                rsp_err_nx     = 1'b1;
                rsp_timeout_nx = 1'b1;
                state_nx       = IDLE;
            end else begin
                cnt_nx = cnt + 1'b1;
            end
            default: begin
                state_nx   = IDLE;
                cnt_nx     = '0;
                psel_nx    = 1'b0;
                penable_nx = 1'b0;
                pwrite_nx  = 1'b0;
                paddr_nx   = '0;
                pwdata_nx  = '0;
                pstrb_nx   = '0;
                pprot_nx   = '0;
            end
        endcase
        // Accepting only happens in IDLE or on a completing ACCESS edge, both handled above.
        if (cmd_valid && cmd_ready) begin
            paddr_nx  = cmd_addr;
            pwrite_nx = cmd_write;
            pwdata_nx = cmd_wdata;
            pstrb_nx  = cmd_write ? cmd_strb : '0;
            pprot_nx  = cmd_prot;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state       <= IDLE;
            cnt         <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            pstrb       <= '0;
            pprot       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            psel        <= psel_nx;
            penable     <= penable_nx;
            pwrite      <= pwrite_nx;
            paddr       <= paddr_nx;
            pwdata      <= pwdata_nx;
            pstrb       <= pstrb_nx;
            pprot       <= pprot_nx;
            rsp_valid   <= rsp_valid_nx;
            rsp_rdata   <= rsp_rdata_nx;
            rsp_err     <= rsp_err_nx;
            rsp_timeout <= rsp_timeout_nx;
        end
    end
endmodule

// File: tb/tb_apb_master_param.sv
// tb_apb_master_param: vector table, hand sequences and random transfers against a
// transaction-level expectation for apb_master_param (TIMEOUT_CYCLES = 4).
module tb_apb_master_param;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 4;

    logic          pclk = 1'b0;
    logic          presetn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [SW-1:0] cmd_strb = '0;
    logic [2:0]    cmd_prot = '0;
    logic          rsp_valid, rsp_err, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [SW-1:0] pstrb;
    logic [2:0]    pprot;
    logic [DW-1:0] prdata = '0;
    logic          pready = 1'b0;
    logic          pslverr = 1'b0;

    always #5 pclk = ~pclk;

    apb_master_param #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .pclk(pclk), .presetn(presetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
        logic [2:0]    prot;
        int            wait_n;
        logic          slverr;
        logic [DW-1:0] prd;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        logic          exp_to;
    } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Transaction-level expectation: a slave that stalls TO cycles or more is aborted.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        logic timed_out = (TO > 0) && (v.wait_n >= TO);
        r.exp_to    = timed_out;
        r.exp_err   = timed_out | v.slverr;
        r.exp_rdata = (timed_out || v.wr) ? '0 : v.prd;
        return r;
    endfunction

    // Starts just after a negedge with the DUT idle; returns just after a negedge, idle again.
    task automatic xfer(input vec_t v, input string tag);
        int n_acc = v.exp_to ? TO : v.wait_n + 1;
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        cmd_strb  = v.strb;
        cmd_prot  = v.prot;
        prdata    = v.prd;
        pready    = 1'b0;
        pslverr   = 1'b0;
        #1 chk({tag, " ready_idle"}, cmd_ready, 1);
        @(negedge pclk);
        cmd_valid = 1'b0;
        cmd_wdata = ~v.wdata;
        pready    = 1'b1;
        pslverr   = 1'b1;
        #1;
        chk({tag, " setup_psel"}, psel, 1);
        chk({tag, " setup_penable"}, penable, 0);
        chk({tag, " setup_ready"}, cmd_ready, 0);
        chk({tag, " paddr"}, paddr, v.addr);
        chk({tag, " pwrite"}, pwrite, v.wr);
        chk({tag, " pwdata"}, pwdata, v.wdata);
        chk({tag, " pstrb"}, pstrb, v.wr ? v.strb : 4'h0);
        chk({tag, " pprot"}, pprot, v.prot);
        for (int i = 0; i < n_acc; i++) begin
            @(negedge pclk);
            pready  = (i >= v.wait_n);
            pslverr = pready ? v.slverr : 1'b1;
            #1;
            chk({tag, " acc_psel"}, psel, 1);
            chk({tag, " acc_penable"}, penable, 1);
            chk({tag, " acc_rsp_valid"}, rsp_valid, 0);
            chk({tag, " acc_ready"}, cmd_ready, pready);
            chk({tag, " acc_paddr"}, paddr, v.addr);
        end
        @(negedge pclk);
        pready  = 1'b0;
        pslverr = 1'b0;
        #1;
        chk({tag, " rsp_valid"}, rsp_valid, 1);
        chk({tag, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
        chk({tag, " rsp_err"}, rsp_err, v.exp_err);
        chk({tag, " rsp_timeout"}, rsp_timeout, v.exp_to);
        chk({tag, " end_psel"}, psel, 0);
        chk({tag, " end_penable"}, penable, 0);
        @(negedge pclk);
        #1 chk({tag, " rsp_pulse"}, rsp_valid, 0);
    endtask

    initial begin
        tbl[0] = '{1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 3'd0, 0,  1'b0, 32'h0,        32'h0,        1'b0, 1'b0};
        tbl[1] = '{1'b0, 8'h24, 32'h0,        4'hF, 3'd2, 3,  1'b0, 32'h12345678, 32'h12345678, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 8'h30, 32'h0,        4'h0, 3'd1, 0,  1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 8'h34, 32'h0,        4'h0, 3'd0, 2,  1'b0, 32'h5A5A5A5A, 32'h5A5A5A5A, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 8'h40, 32'h0,        4'h0, 3'd0, 20, 1'b0, 32'hFFFFFFFF, 32'h0,        1'b1, 1'b1};
        tbl[5] = '{1'b0, 8'h44, 32'h0,        4'h0, 3'd0, 3,  1'b0, 32'h0BADF00D, 32'h0BADF00D, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 8'h48, 32'h11223344, 4'h3, 3'd5, 4,  1'b0, 32'h0,        32'h0,        1'b1, 1'b1};
        tbl[7] = '{1'b1, 8'hFF, 32'hCAFEF00D, 4'h8, 3'd7, 1,  1'b1, 32'h99999999, 32'h0,        1'b1, 1'b0};

        repeat (2) @(negedge pclk);
        #1;
        chk("reset psel", psel, 0);
        chk("reset penable", penable, 0);
        chk("reset paddr", paddr, 0);
        chk("reset pstrb", pstrb, 0);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset rsp_err", rsp_err, 0);
        chk("reset cmd_ready", cmd_ready, 1);
        @(negedge pclk);
        presetn = 1'b1;
        #1;

        for (int k = 0; k < 8; k++) xfer(tbl[k], $sformatf("vec%0d", k));

        // Back-to-back writes with cmd_valid held high.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h50; cmd_wdata = 32'h11111111;
        cmd_strb = 4'hF; cmd_prot = 3'd0; pready = 1'b1; pslverr = 1'b0;
        @(negedge pclk); #1;
        chk("b2b setup1 psel", psel, 1);
        chk("b2b setup1 penable", penable, 0);
        chk("b2b setup1 paddr", paddr, 8'h50);
        cmd_addr = 8'h54; cmd_wdata = 32'h22222222;
        @(negedge pclk); #1;
        chk("b2b acc1 psel", psel, 1);
        chk("b2b acc1 penable", penable, 1);
        chk("b2b acc1 ready", cmd_ready, 1);
        chk("b2b acc1 rsp_valid", rsp_valid, 0);
        @(negedge pclk); #1;
        chk("b2b rsp1 valid", rsp_valid, 1);
        chk("b2b setup2 psel", psel, 1);
        chk("b2b setup2 penable", penable, 0);
        chk("b2b setup2 paddr", paddr, 8'h54);
        chk("b2b setup2 pwdata", pwdata, 32'h22222222);
        cmd_valid = 1'b0;
        @(negedge pclk); #1;
        chk("b2b acc2 psel", psel, 1);
        chk("b2b acc2 penable", penable, 1);
        chk("b2b acc2 rsp_valid", rsp_valid, 0);
        @(negedge pclk); #1;
        chk("b2b rsp2 valid", rsp_valid, 1);
        chk("b2b rsp2 err", rsp_err, 0);
        chk("b2b end psel", psel, 0);
        pready = 1'b0;
        @(negedge pclk); #1;

        // Reset asserted in the middle of ACCESS.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h60; pready = 1'b0;
        @(negedge pclk); #1;
        cmd_valid = 1'b0;
        @(negedge pclk); #1;
        chk("rst mid penable", penable, 1);
        presetn = 1'b0;
        #1;
        chk("rst mid psel", psel, 0);
        chk("rst mid penable0", penable, 0);
        chk("rst mid rsp_valid", rsp_valid, 0);
        chk("rst mid paddr", paddr, 0);
        @(negedge pclk); #1;
        chk("rst hold rsp_valid", rsp_valid, 0);
        @(negedge pclk);
        presetn = 1'b1;
        #1;
        chk("rst rel rsp_valid", rsp_valid, 0);
        xfer(tbl[1], "post_rst");

        for (int k = 0; k < 40; k++) begin
            vec_t v;
            v.wr     = 1'($urandom);
            v.addr   = AW'($urandom);
            v.wdata  = $urandom;
            v.strb   = SW'($urandom);
            v.prot   = 3'($urandom);
            v.wait_n = int'($urandom_range(0, 6));
            v.slverr = 1'($urandom);
            v.prd    = $urandom;
            xfer(model(v), $sformatf("rnd%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
